// File: rtl/fetch_decode.sv
// Instruction fetch/decode front end: fetches a one- or two-byte instruction
// from a byte-wide memory with one-cycle read latency, decodes the opcode
// fields and presents them to the ALU/writeback stage through a valid/ready
// handshake. A jump request restarts fetching at the redirect address.
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [2:0]  alu_operation,
  output logic        alu_operand,
  output logic [3:0]  rx_sel,
  output logic [7:0]  immediate,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr
);

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 3;
  localparam int unsigned RW  = 4;

  typedef enum logic [2:0] {
    OP_REQ  = 3'd0,
    OP_CAP  = 3'd1,
    IMM_REQ = 3'd2,
    IMM_CAP = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_rd;
  logic [AW-1:0]    r_pc;
  logic             r_valid;
  logic [OPW-1:0]   r_op;
  logic             r_operand;
  logic [RW-1:0]    r_rx;
  logic [DW-1:0]    r_imm;
  logic [AW-1:0]    r_ipc;

  // State register; reset always restarts at the opcode request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OP_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and read-strobe decode; a redirect overrides every state.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    case (r_state)
      OP_REQ: begin
        w_rd   = 1'b1;
        w_next = OP_CAP;
      end
      OP_CAP:  w_next = mem_rdata[7] ? IMM_REQ : OUT;
      IMM_REQ: begin
        w_rd   = 1'b1;
        w_next = IMM_CAP;
      end
      IMM_CAP: w_next = OUT;
      OUT:     if (instr_ready) w_next = OP_REQ;
      default: w_next = OP_REQ;
    endcase
    if (redirect_valid) w_next = OP_REQ;
  end

  // Valid flag follows entry into OUT; cleared by reset and by any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_next == OUT);
    end
  end

  // PC and decoded fields; capture only in the two capture states so stale
  // read data after a redirect is never sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_op      <= '0;
      r_operand <= 1'b0;
      r_rx      <= '0;
      r_imm     <= '0;
      r_ipc     <= '0;
    end else if (redirect_valid) begin
      r_pc <= redirect_addr;
    end else begin
      case (r_state)
        OP_CAP: begin
          r_op      <= mem_rdata[6:4];
          r_operand <= mem_rdata[7];
          r_rx      <= mem_rdata[3:0];
          r_imm     <= '0;
          r_ipc     <= r_pc;
          r_pc      <= r_pc + AW'(1);
        end
        IMM_CAP: begin
          r_imm <= mem_rdata;
          r_pc  <= r_pc + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Memory request is a state decode, held idle while reset is asserted so
  // the first strobe lands in the first cycle after release.
  assign mem_rd_en     = w_rd & ~rst;
  assign mem_addr      = rst ? RESET_PC : r_pc;

  assign instr_valid   = r_valid;
  assign alu_operation = r_op;
  assign alu_operand   = r_operand;
  assign rx_sel        = r_rx;
  assign immediate     = r_imm;
  assign instr_pc      = r_ipc;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed scenarios followed by a randomized run
// against an instruction-level reference model of fetch timing and decode.
module tb_fetch_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  alu_operation;
  logic        alu_operand;
  logic [3:0]  rx_sel;
  logic [7:0]  immediate;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_addr;

  logic [15:0] w_mem_addr;
  logic        w_mem_rd_en;
  logic [7:0]  w_mem_rdata;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [2:0]  w_alu_operation;
  logic        w_alu_operand;
  logic [3:0]  w_rx_sel;
  logic [7:0]  w_immediate;
  logic [15:0] w_instr_pc;
  logic        w_redirect_valid;
  logic [15:0] w_redirect_addr;

  logic [7:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  fetch_decode dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_operation(alu_operation), .alu_operand(alu_operand),
    .rx_sel(rx_sel), .immediate(immediate), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  fetch_decode #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst),
    .mem_addr(w_mem_addr), .mem_rd_en(w_mem_rd_en), .mem_rdata(w_mem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .alu_operation(w_alu_operation), .alu_operand(w_alu_operand),
    .rx_sel(w_rx_sel), .immediate(w_immediate), .instr_pc(w_instr_pc),
    .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr)
  );

  // Memory with one-cycle read latency; unstrobed cycles return junk.
  always @(posedge clk) begin
    mem_rdata   <= mem_rd_en   ? mem[mem_addr]   : 8'($urandom);
    w_mem_rdata <= w_mem_rd_en ? mem[w_mem_addr] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_fields(input string tag, input logic [2:0] op, input logic opnd,
                            input logic [3:0] rx, input logic [7:0] imm, input logic [15:0] pc);
    chk({tag, "_op"},   32'(alu_operation), 32'(op));
    chk({tag, "_opnd"}, 32'(alu_operand),   32'(opnd));
    chk({tag, "_rx"},   32'(rx_sel),        32'(rx));
    chk({tag, "_imm"},  32'(immediate),     32'(imm));
    chk({tag, "_ipc"},  32'(instr_pc),      32'(pc));
  endtask

  logic [15:0] mp;
  logic [15:0] mp1;
  logic [7:0]  opb;
  logic        has_imm;
  int          k;
  int          lat;
  logic        vexp;
  logic        rexp;

  initial begin
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 16'h0000;
    w_instr_ready = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Plain register instruction at 0, ready high.
    mem[0] = 8'h25;
    step(); step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rden",  32'(mem_rd_en),   32'd0);
    chk("rst_addr",  32'(mem_addr),    32'h0000);
    chk_fields("rst", 3'd0, 1'b0, 4'd0, 8'h00, 16'h0000);
    release_rst();
    chk("t1_c0_rden",  32'(mem_rd_en),   32'd1);
    chk("t1_c0_addr",  32'(mem_addr),    32'h0000);
    chk("t1_c0_valid", 32'(instr_valid), 32'd0);
    step();
    chk("t1_c1_valid", 32'(instr_valid), 32'd0);
    chk("t1_c1_rden",  32'(mem_rd_en),   32'd0);
    step();
    chk("t1_c2_valid", 32'(instr_valid), 32'd1);
    chk_fields("t1", 3'd2, 1'b0, 4'd5, 8'h00, 16'h0000);
    step();
    chk("t1_next_rden", 32'(mem_rd_en), 32'd1);
    chk("t1_next_addr", 32'(mem_addr),  32'h0001);

    // Immediate instruction, then backpressure, then redirect in IMM_CAP.
    mem[0] = 8'hF3; mem[1] = 8'h04; mem[2] = 8'h9B; mem[3] = 8'h55;
    mem[16'h0100] = 8'h3C;
    instr_ready = 1'b0;
    rst = 1'b1;
    step();
    release_rst();
    chk("t2_c0_addr", 32'(mem_addr), 32'h0000);
    step(); step();
    chk("t2_c2_rden",  32'(mem_rd_en),   32'd1);
    chk("t2_c2_addr",  32'(mem_addr),    32'h0001);
    chk("t2_c2_valid", 32'(instr_valid), 32'd0);
    step();
    chk("t2_c3_valid", 32'(instr_valid), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
      chk("t2_hold_rden",  32'(mem_rd_en),   32'd0);
      chk_fields("t2_hold", 3'd7, 1'b1, 4'd3, 8'h04, 16'h0000);
      step();
    end
    chk("t2_last_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    step();
    chk("t2_next_rden",  32'(mem_rd_en),   32'd1);
    chk("t2_next_addr",  32'(mem_addr),    32'h0002);
    chk("t2_next_valid", 32'(instr_valid), 32'd0);
    step(); step();
    chk("t3_immreq_addr", 32'(mem_addr), 32'h0003);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0100;
    step();
    redirect_valid = 1'b0;
    chk("t3_redir_rden",  32'(mem_rd_en),   32'd1);
    chk("t3_redir_addr",  32'(mem_addr),    32'h0100);
    chk("t3_redir_valid", 32'(instr_valid), 32'd0);
    step();
    chk("t3_c1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("t3_c2_valid", 32'(instr_valid), 32'd1);
    chk_fields("t3", 3'd3, 1'b0, 4'hC, 8'h00, 16'h0100);

    // Reset asserted while in IMM_REQ.
    rst = 1'b1;
    step();
    release_rst();
    step(); step();
    chk("t4_immreq_addr", 32'(mem_addr), 32'h0001);
    rst = 1'b1;
    #1;
    step();
    chk("t4_rst_valid", 32'(instr_valid), 32'd0);
    chk("t4_rst_rden",  32'(mem_rd_en),   32'd0);
    chk("t4_rst_addr",  32'(mem_addr),    32'h0000);
    chk_fields("t4_rst", 3'd0, 1'b0, 4'd0, 8'h00, 16'h0000);
    release_rst();
    chk("t4_rel_rden", 32'(mem_rd_en), 32'd1);
    chk("t4_rel_addr", 32'(mem_addr),  32'h0000);

    // PC wrap with RESET_PC at the top of memory.
    mem[16'hFFFF] = 8'h80; mem[0] = 8'hAA;
    rst = 1'b1;
    step();
    release_rst();
    chk("t5_c0_addr", 32'(w_mem_addr), 32'hFFFF);
    step(); step();
    chk("t5_c2_rden", 32'(w_mem_rd_en), 32'd1);
    chk("t5_c2_addr", 32'(w_mem_addr),  32'h0000);
    step(); step();
    chk("t5_valid", 32'(w_instr_valid),   32'd1);
    chk("t5_op",    32'(w_alu_operation), 32'd0);
    chk("t5_opnd",  32'(w_alu_operand),   32'd1);
    chk("t5_rx",    32'(w_rx_sel),        32'd0);
    chk("t5_imm",   32'(w_immediate),     32'h00AA);
    chk("t5_ipc",   32'(w_instr_pc),      32'hFFFF);
    step();
    chk("t5_next_addr", 32'(w_mem_addr), 32'h0001);

    // Randomized run against the instruction-level model.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    step();
    release_rst();
    mp = 16'h0000;
    k  = 0;
    for (int c = 0; c < 800; c++) begin
      opb     = mem[mp];
      has_imm = opb[7];
      mp1     = mp + 16'd1;
      lat     = has_imm ? 4 : 2;
      vexp    = (k >= lat);
      rexp    = (k == 0) || (has_imm && k == 2);
      chk("rnd_valid", 32'(instr_valid), 32'(vexp));
      chk("rnd_rden",  32'(mem_rd_en),   32'(rexp));
      if (rexp) chk("rnd_addr", 32'(mem_addr), 32'((k == 0) ? mp : mp1));
      if (vexp) chk_fields("rnd", opb[6:4], has_imm, opb[3:0],
                           has_imm ? mem[mp1] : 8'h00, mp);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_addr  = 16'($urandom);
      step();
      if (redirect_valid) begin
        mp = redirect_addr;
        k  = 0;
      end else if (vexp && instr_ready) begin
        mp = has_imm ? mp + 16'd2 : mp + 16'd1;
        k  = 0;
      end else if (!vexp) begin
        k++;
      end
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
